// File: rtl/bcd_share_sched.sv
// Time-shared double-dabble converter: four binary time fields become packed BCD in one frame.
// Optional range checking (clamp to all-9s, ovf flags) is built when BCD_RANGE_CHECK_EN is defined.
module bcd_share_sched #(
  parameter int IN_W = 14
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [IN_W-1:0] small_sec_in,
  input  logic [IN_W-1:0] sec_in,
  input  logic [IN_W-1:0] min_in,
  input  logic [IN_W-1:0] hr_in,
  output logic [15:0]     small_bcd,
  output logic [7:0]      sec_bcd,
  output logic [7:0]      min_bcd,
  output logic [7:0]      hr_bcd,
  output logic            busy,
  output logic            done,
  output logic [3:0]      ovf,
  output logic [2:0]      o_dbg_state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_SHIFT  = 3'd2;
  localparam logic [2:0] S_STORE  = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;
  localparam int CNT_W = $clog2(IN_W + 1);

  // Handshake: start is sampled every rising edge; it is accepted only when the FSM is
  // in IDLE or COMMIT (busy=0). done is a one-cycle pulse in COMMIT, when outputs change.
  logic [2:0]       r_state;
  logic [1:0]       r_field;
  logic [CNT_W-1:0] r_cnt;
  logic [IN_W-1:0]  r_snap [4];
  logic [IN_W-1:0]  r_bin;
  logic [15:0]      r_acc;
  logic [15:0]      r_res_small;
  logic [7:0]       r_res_sec;
  logic [7:0]       r_res_min;
  logic [15:0]      r_small_bcd;
  logic [7:0]       r_sec_bcd;
  logic [7:0]       r_min_bcd;
  logic [7:0]       r_hr_bcd;
  logic             r_done;
  logic [15:0]      w_adj;
  logic             w_accept;
  logic             w_last_bit;

  always_comb begin
    w_adj = r_acc;
    for (int i = 0; i < 4; i++) begin
      if (r_acc[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
    end
  end

  assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_COMMIT));
  assign w_last_bit = (r_cnt == CNT_W'(IN_W - 1));

`ifdef BCD_RANGE_CHECK_EN
  logic [3:0] w_ovf;
  logic [3:0] r_ovf;
  assign w_ovf[0] = 32'(r_snap[0]) > 32'd9999;
  assign w_ovf[1] = 32'(r_snap[1]) > 32'd99;
  assign w_ovf[2] = 32'(r_snap[2]) > 32'd99;
  assign w_ovf[3] = 32'(r_snap[3]) > 32'd99;
  assign ovf      = r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= '0;
    end else if (r_state == S_STORE && r_field == 2'd3) begin
      r_ovf <= w_ovf;
    end
  end
`else
  assign ovf = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_field     <= '0;
      r_cnt       <= '0;
      r_bin       <= '0;
      r_acc       <= '0;
      r_res_small <= '0;
      r_res_sec   <= '0;
      r_res_min   <= '0;
      r_small_bcd <= '0;
      r_sec_bcd   <= '0;
      r_min_bcd   <= '0;
      r_hr_bcd    <= '0;
      r_done      <= 1'b0;
      for (int i = 0; i < 4; i++) r_snap[i] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_LOAD: begin
          r_acc   <= '0;
          r_bin   <= r_snap[r_field];
          r_cnt   <= '0;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          {r_acc, r_bin} <= {w_adj[14:0], r_bin, 1'b0};
          r_cnt          <= r_cnt + 1'b1;
          if (w_last_bit) r_state <= S_STORE;
        end
        S_STORE: begin
          case (r_field)
            2'd0:    r_res_small <= r_acc;
            2'd1:    r_res_sec   <= r_acc[7:0];
            2'd2:    r_res_min   <= r_acc[7:0];
            default: r_res_min   <= r_res_min;
          endcase
          if (r_field == 2'd3) begin
            // hr goes straight to the outputs so all four fields change on the same edge
`ifdef BCD_RANGE_CHECK_EN
            r_small_bcd <= w_ovf[0] ? 16'h9999 : r_res_small;
            r_sec_bcd   <= w_ovf[1] ? 8'h99 : r_res_sec;
            r_min_bcd   <= w_ovf[2] ? 8'h99 : r_res_min;
            r_hr_bcd    <= w_ovf[3] ? 8'h99 : r_acc[7:0];
`else
            r_small_bcd <= r_res_small;
            r_sec_bcd   <= r_res_sec;
            r_min_bcd   <= r_res_min;
            r_hr_bcd    <= r_acc[7:0];
`endif
            r_done  <= 1'b1;
            r_state <= S_COMMIT;
          end else begin
            r_field <= r_field + 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_COMMIT: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
      if (w_accept) begin
        r_snap[0] <= small_sec_in;
        r_snap[1] <= sec_in;
        r_snap[2] <= min_in;
        r_snap[3] <= hr_in;
        r_field   <= '0;
        r_state   <= S_LOAD;
      end
    end
  end

  assign small_bcd   = r_small_bcd;
  assign sec_bcd     = r_sec_bcd;
  assign min_bcd     = r_min_bcd;
  assign hr_bcd      = r_hr_bcd;
  assign done        = r_done;
  assign busy        = (r_state == S_LOAD) || (r_state == S_SHIFT) || (r_state == S_STORE);
  assign o_dbg_state = r_state;

endmodule
